// File: rtl/pcie_dma_pkg.sv
// Shared types and constants for the PCIe DMA burst reader.
// Burst geometry helpers, FSM state encoding and the header record.
package pcie_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    NEXT = 2'd3
  } state_e;

  localparam int DATA_W_DEF    = 128;
  localparam int BURST_LEN_DEF = 32;
  localparam int HDR_ADDR_W    = 32;
  localparam int HDR_LEN_W     = 9;
  localparam int BURST_BYTES   = BURST_LEN_DEF * DATA_W_DEF / 8;

  typedef struct packed {
    logic [HDR_ADDR_W-1:0] addr;
    logic [HDR_LEN_W-1:0]  len;
  } hdr_t;

  function automatic int burst_bytes(input int len, input int dw);
    return len * dw / 8;
  endfunction

endpackage

// File: rtl/pcie_skid_buf.sv
// Two-entry buffer between the FIFO read port and the DMA beat stream.
// Head entry stays put until popped, so the beat payload is stable under stall.
module pcie_skid_buf #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pcie_fifo_burst_reader.sv
// Drains fixed-size bursts from the pixel FIFO into the PCIe DMA write engine,
// walking a circular host frame buffer and flagging each frame wrap.
module pcie_fifo_burst_reader
  import pcie_dma_pkg::*;
#(
  parameter int                DATA_W      = 128,
  parameter int                LEVEL_W     = 13,
  parameter int                BURST_LEN   = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(32'h003F_4800)
) (
  input  logic               rd_clk,
  input  logic               rd_rst,
  input  logic               dma_en,
  output logic               fifo_rd_en,
  input  logic [DATA_W-1:0]  fifo_rd_data,
  input  logic               fifo_rd_empty,
  input  logic [LEVEL_W-1:0] fifo_rd_water_level,
  output logic               hdr_valid,
  input  logic               hdr_ready,
  output logic [ADDR_W-1:0]  hdr_addr,
  output logic [8:0]         hdr_len,
  output logic               dat_valid,
  input  logic               dat_ready,
  output logic [DATA_W-1:0]  dat_data,
  output logic               dat_last,
  output logic               frame_done,
  output logic               underflow_err
);

  localparam logic [ADDR_W-1:0]  BURST_B  = ADDR_W'(burst_bytes(BURST_LEN, DATA_W));
  localparam logic [ADDR_W-1:0]  END_ADDR = BASE_ADDR + FRAME_BYTES;
  localparam logic [8:0]         LEN9     = 9'(BURST_LEN);
  localparam logic [LEVEL_W-1:0] LVL_MIN  = LEVEL_W'(BURST_LEN);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_inc;
  logic              addr_wrap;
  logic [8:0]        pops_left;
  logic              inflight;
  logic              inflight_last;
  logic              underflow_q;
  logic              start_burst;
  logic              beat_fire;
  logic              pop_req;
  logic [2:0]        occ_sum;
  logic [1:0]        skid_cnt;
  logic [DATA_W:0]   skid_head;

  assign addr_inc  = addr_q + BURST_B;
  assign addr_wrap = (addr_inc == END_ADDR);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_burst = 1'b0;
    hdr_valid   = 1'b0;
    dat_valid   = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dma_en && (fifo_rd_water_level >= LVL_MIN)) begin
          state_d     = HDR;
          start_burst = 1'b1;
        end
      end
      HDR: begin
        hdr_valid = 1'b1;
        if (hdr_ready) state_d = DATA;
      end
      DATA: begin
        dat_valid = (skid_cnt != 2'd0);
        if (dat_valid && dat_ready && skid_head[DATA_W]) state_d = NEXT;
      end
      NEXT: begin
        frame_done = addr_wrap;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat_fire = dat_valid && dat_ready;

  // Credit counts the head leaving this cycle so a full skid can still refill
  // behind a consumed beat and sustain one beat per cycle.
  always_comb begin
    occ_sum = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, beat_fire};
    pop_req = (pops_left != 9'd0) && (occ_sum < 3'd2);
  end

  assign fifo_rd_en = pop_req && !fifo_rd_empty;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      addr_q        <= BASE_ADDR;
      pops_left     <= 9'd0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      inflight      <= fifo_rd_en;
      inflight_last <= fifo_rd_en && (pops_left == 9'd1);
      if (start_burst)     pops_left <= LEN9;
      else if (fifo_rd_en) pops_left <= pops_left - 9'd1;
      if (state_q == NEXT) addr_q <= addr_wrap ? BASE_ADDR : addr_inc;
      if (pop_req && fifo_rd_empty) underflow_q <= 1'b1;
    end
  end

  // The last flag travels with the word that was the final pop of the burst.
  pcie_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (inflight),
    .push_data ({inflight_last, fifo_rd_data}),
    .pop       (beat_fire),
    .head      (skid_head),
    .count     (skid_cnt)
  );

  assign hdr_addr      = addr_q;
  assign hdr_len       = hdr_valid ? LEN9 : 9'd0;
  assign dat_data      = skid_head[DATA_W-1:0];
  assign dat_last      = dat_valid && skid_head[DATA_W];
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_pcie_fifo_burst_reader.sv
// Directed bench for pcie_fifo_burst_reader with a behavioural FIFO (1-cycle read latency)
// and a table of bursts, plus hand sequences for disable, reset and underflow corners.
module tb_pcie_fifo_burst_reader;
  localparam int          DW    = 128;
  localparam int          LW    = 13;
  localparam int          BL    = 32;
  localparam int          AW    = 32;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] FRAME = 32'h0000_0800;

  logic           rd_clk = 1'b0;
  logic           rd_rst = 1'b1;
  logic           dma_en = 1'b0;
  logic           fifo_rd_en;
  logic [DW-1:0]  fifo_rd_data = '0;
  logic           fifo_rd_empty;
  logic [LW-1:0]  fifo_rd_water_level = '0;
  logic           hdr_valid;
  logic           hdr_ready = 1'b0;
  logic [AW-1:0]  hdr_addr;
  logic [8:0]     hdr_len;
  logic           dat_valid;
  logic           dat_ready = 1'b0;
  logic [DW-1:0]  dat_data;
  logic           dat_last;
  logic           frame_done;
  logic           underflow_err;

  int n_cmp = 0;
  int n_bad = 0;
  int push_total = 0;
  int pushed = 0;
  int popped = 0;
  int accepted = 0;
  int exp_seq = 0;
  logic force_empty = 1'b0;
  logic [DW-1:0] q [$];

  always #5 rd_clk = ~rd_clk;

  pcie_fifo_burst_reader #(
    .DATA_W(DW), .LEVEL_W(LW), .BURST_LEN(BL), .ADDR_W(AW),
    .BASE_ADDR(BASE), .FRAME_BYTES(FRAME)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .dma_en(dma_en),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(fifo_rd_water_level),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_addr(hdr_addr), .hdr_len(hdr_len),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data), .dat_last(dat_last),
    .frame_done(frame_done), .underflow_err(underflow_err)
  );

  function automatic logic [DW-1:0] word(input int n);
    logic [31:0] v;
    v = n;
    return {v, ~v, v ^ 32'h5A5A_5A5A, v | 32'hC0DE_0000};
  endfunction

  // FIFO model: words are numbered by push order; rd_rst flushes everything pending.
  always @(posedge rd_clk) begin
    if (rd_rst) begin
      q.delete();
      pushed <= push_total;
      popped <= 0;
    end else begin
      if (fifo_rd_en) begin
        fifo_rd_data <= q.pop_front();
        popped       <= popped + 1;
      end
      for (int i = pushed; i < push_total; i++) q.push_back(word(i));
      pushed <= push_total;
    end
    fifo_rd_water_level <= LW'(q.size());
  end

  assign fifo_rd_empty = force_empty || (fifo_rd_water_level == '0);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input bit tog, input int hwait, input logic [31:0] exp_addr,
                           input bit exp_fd, input int drop_at, input int rst_at,
                           input int empty_at);
    int cyc = 0, beats = 0, tail = 0, hw = hwait, ehold = 0;
    int fd_cnt = 0, fd_early = 0, ahead_max = 0;
    bit hdr_seen = 0, hdr_done = 0, done = 0, stall = 0, rdy;
    bit ok_hstab = 1, ok_stable = 1, ok_order = 1, ok_empty = 1;
    logic [DW-1:0] stall_data = '0;
    logic stall_last = 1'b0;
    hdr_ready = 1'b0;
    dat_ready = 1'b0;
    while (!done && cyc < 800) begin
      @(negedge rd_clk);
      cyc++;
      if (frame_done) begin
        if (beats == BL) fd_cnt++;
        else fd_early++;
      end
      if (popped - accepted > ahead_max) ahead_max = popped - accepted;
      if (!hdr_done) begin
        if (hdr_valid) begin
          if (!hdr_seen) begin
            hdr_seen = 1;
            chk("hdr_addr", 128'(hdr_addr), 128'(exp_addr));
            chk("hdr_len", 128'(hdr_len), 128'(BL));
          end else if (hdr_addr !== exp_addr || hdr_len !== 9'(BL)) ok_hstab = 0;
          if (hw == 0) begin
            hdr_ready = 1'b1;
            hdr_done  = 1;
          end else hw--;
        end else if (hdr_seen) ok_hstab = 0;
      end else begin
        hdr_ready = 1'b0;
        if (stall) begin
          if (!dat_valid || dat_data !== stall_data || dat_last !== stall_last) ok_stable = 0;
          stall = 0;
        end
        if (ehold > 0 && ehold < 7) begin
          if (fifo_rd_en) ok_empty = 0;
          ehold++;
          if (ehold == 7) begin
            chk("underflow_set", 128'(underflow_err), 128'(1));
            chk("no_pop_while_empty", 128'(ok_empty), 128'(1));
            force_empty = 1'b0;
          end
        end
        if (empty_at >= 0 && beats == empty_at && ehold == 0) begin
          force_empty = 1'b1;
          ehold = 1;
        end
        if (drop_at >= 0 && beats == drop_at) dma_en = 1'b0;
        if (rst_at >= 0 && beats == rst_at) begin
          rd_rst    = 1'b1;
          dat_ready = 1'b0;
          accepted  = 0;
          @(negedge rd_clk);
          chk("rst_ctrl_outputs",
              128'({hdr_valid, dat_valid, dat_last, fifo_rd_en, frame_done, underflow_err}), 128'(0));
          chk("rst_hdr_addr", 128'(hdr_addr), 128'(BASE));
          chk("rst_dat_data", 128'(dat_data), 128'(0));
          chk("rst_hdr_len", 128'(hdr_len), 128'(0));
          rd_rst  = 1'b0;
          exp_seq = push_total;
          return;
        end
        rdy = tog ? (cyc % 2 == 0) : 1'b1;
        dat_ready = rdy;
        if (dat_valid && rdy) begin
          if (dat_data !== word(exp_seq) || dat_last !== (beats == BL - 1)) ok_order = 0;
          exp_seq++;
          beats++;
          accepted++;
        end else if (dat_valid) begin
          stall      = 1;
          stall_data = dat_data;
          stall_last = dat_last;
        end
        if (beats == BL) begin
          tail++;
          if (tail == 3) done = 1;
        end
      end
    end
    dat_ready = 1'b0;
    chk("burst_done", 128'(done), 128'(1));
    chk("beat_count", 128'(beats), 128'(BL));
    chk("beat_order_last", 128'(ok_order), 128'(1));
    chk("ahead_le_2", 128'(ahead_max <= 2), 128'(1));
    chk("frame_done_cnt", 128'(fd_cnt), 128'(exp_fd));
    chk("frame_done_early", 128'(fd_early), 128'(0));
    if (tog) chk("stall_stable", 128'(ok_stable), 128'(1));
    if (hwait > 0) chk("hdr_stable", 128'(ok_hstab), 128'(1));
  endtask

  typedef struct {
    int          fill;
    bit          tog;
    int          hwait;
    logic [31:0] addr;
    bit          fd;
  } vec_t;

  vec_t vt [6];

  initial begin
    bit seen;
    vt[0] = '{1,  1'b0, 0, 32'h000, 1'b0};
    vt[1] = '{32, 1'b1, 2, 32'h200, 1'b0};
    vt[2] = '{40, 1'b0, 0, 32'h400, 1'b0};
    vt[3] = '{24, 1'b1, 0, 32'h600, 1'b1};
    vt[4] = '{32, 1'b0, 1, 32'h000, 1'b0};
    vt[5] = '{32, 1'b0, 0, 32'h200, 1'b0};

    repeat (3) @(negedge rd_clk);
    chk("reset_ctrl",
        128'({hdr_valid, dat_valid, dat_last, fifo_rd_en, frame_done, underflow_err}), 128'(0));
    chk("reset_hdr_addr", 128'(hdr_addr), 128'(BASE));
    rd_rst = 1'b0;
    dma_en = 1'b1;

    // one word short of a burst: nothing may start
    push_total = 31;
    seen = 0;
    repeat (10) begin
      @(negedge rd_clk);
      if (hdr_valid || fifo_rd_en) seen = 1;
    end
    chk("no_hdr_below_level", 128'(seen), 128'(0));

    for (int i = 0; i < 6; i++) begin
      push_total = push_total + vt[i].fill;
      run_burst(vt[i].tog, vt[i].hwait, vt[i].addr, vt[i].fd, -1, -1, -1);
    end
    chk("underflow_clear", 128'(underflow_err), 128'(0));

    // dma_en dropped mid-burst: burst completes, then nothing new starts
    push_total = push_total + 32;
    run_burst(1'b0, 0, 32'h400, 1'b0, 10, -1, -1);
    push_total = push_total + 32;
    seen = 0;
    repeat (40) begin
      @(negedge rd_clk);
      if (hdr_valid || fifo_rd_en) seen = 1;
    end
    chk("no_hdr_when_disabled", 128'(seen), 128'(0));

    // reset mid-burst, then restart from the base address
    dma_en = 1'b1;
    run_burst(1'b0, 0, 32'h600, 1'b0, -1, 5, -1);
    push_total = push_total + 32;
    run_burst(1'b0, 0, BASE, 1'b0, -1, -1, -1);

    // forced empty mid-burst
    push_total = push_total + 32;
    run_burst(1'b0, 0, 32'h200, 1'b0, -1, -1, 20);
    chk("underflow_sticky", 128'(underflow_err), 128'(1));
    rd_rst = 1'b1;
    @(negedge rd_clk);
    rd_rst = 1'b0;
    @(negedge rd_clk);
    chk("underflow_rst_clear", 128'(underflow_err), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
